mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares a single 32-bit memory port between the instruction-fetch requester and the data-access requester of the CPU.
- Sequences every transaction through a small FSM and registers the address, write data and read data.
- Returns read data and a one-cycle acknowledge to the owning requester.
- Data access has priority; an anti-starvation counter guarantees fetch progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 2, consecutive data grants allowed while fetch is waiting before fetch is forced to win (≥1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  AW  fetch address; stable while if_req is high.
- if_rdata  output  DW  fetched word; valid in the if_ack cycle and held until the next fetch completes.
- if_ack  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  write data.
- d_rdata  output  DW  load data; valid in the d_ack cycle of a read and held thereafter.
- d_ack  output  1  one-cycle data completion pulse.
- mem_req  output  1  memory request; registered.
- mem_we  output  1  memory write enable; registered.
- mem_addr  output  AW  memory address; registered.
- mem_wdata  output  DW  memory write data; registered.
- mem_rdata  input  DW  memory read data; sampled when mem_rdy=1 in WAIT.
- mem_rdy  input  1  memory completion, one cycle.
- busy  output  1  1 when state ≠ IDLE.
- owner  output  1  current owner: 0 = fetch, 1 = data. Meaningful in WAIT and RESP.

Behaviour:
- Reset (reset=0, takes effect asynchronously):
  - state=IDLE.
  - mem_req, mem_we, if_ack, d_ack, owner and starve_cnt = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With no request, stay in IDLE; all outputs hold.
  - With any request, pick a winner on the rising edge. The winner's addr, wdata and we are latched into the mem_* registers. mem_req goes to 1, owner is set, next state is WAIT.
  - For a fetch winner, mem_we=0 and mem_wdata holds its previous value.
- Arbitration (evaluated only in IDLE):
  - Only one request: that requester wins.
  - Both requesting and starve_cnt == STARVE_MAX: fetch wins.
  - Both requesting otherwise: data wins.
- starve_cnt (saturates at STARVE_MAX):
  - Increments on a data grant while if_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant while if_req=0.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On mem_rdy=1, the owner's rdata register captures mem_rdata, but only for reads; writes leave d_rdata unchanged.
  - On mem_rdy=1, mem_req and mem_we clear and next state is RESP.
  - No timeout: WAIT is held indefinitely until mem_rdy.
- RESP:
  - The owner's ack is 1 for exactly this cycle; next state is IDLE.
  - No arbitration occurs in RESP, so a requester that drops req on the ack edge is never re-granted.
- Latency: req first seen in IDLE at cycle 0 → mem_req=1 in cycle 1. If mem_rdy=1 in cycle 1 → ack in cycle 2 → IDLE in cycle 3.
- Throughput: a requester holding req continuously gets at most one transaction per 3 cycles.
- Boundary conditions:
  - mem_rdy outside WAIT is ignored.
  - A requester dropping req during WAIT is a protocol violation. The transaction still completes and ack still pulses.
  - Changes to the inputs of the non-owning requester during WAIT or RESP have no effect.
  - Reset asserted mid-WAIT or mid-RESP: mem_req and the acks drop immediately and no ack is issued. A late mem_rdy after release is ignored in IDLE.
  - The if_ack/d_ack pulse is never emitted without a preceding mem_rdy.
  - if_ack and d_ack are never high in the same cycle.
- Widths: pure transfer, no arithmetic besides starve_cnt. starve_cnt is $clog2(STARVE_MAX+1) bits wide.

Test Plan:
- Reset: hold reset=0 with if_req=d_req=1 → all outputs 0, busy=0. Release reset → first grant occurs on the next edge.
- Single fetch: if_req=1, if_addr=0x00000100, mem_rdy=1 in the first WAIT cycle, mem_rdata=0xE3A00001.
  - Cycle 1: mem_req=1, mem_addr=0x100, mem_we=0.
  - Cycle 2: if_ack=1, if_rdata=0xE3A00001.
  - Cycle 3: busy=0.
- Collision: in the same cycle, d_req read @0x2000 and if_req @0x104 are both asserted, with starve_cnt=0.
  - Data is served first: owner=1, d_ack then, d_rdata = mem value.
  - Fetch is served next: mem_addr=0x104 in the following WAIT.
- Starvation, STARVE_MAX=2: both requesters held continuously and mem_rdy is immediate → grant order D,D,F,D,D,F; starve_cnt sequence 1,2,0,1,2,0.
- Delayed write: d_req=1, d_we=1, d_addr=0x3000, d_wdata=0xDEADBEEF, mem_rdy asserted 4 cycles after mem_req.
  - mem_we=1, mem_addr and mem_wdata stable for all 4 WAIT cycles.
  - d_ack 1 cycle after mem_rdy.
  - d_rdata unchanged.
- Reset mid-WAIT: pull reset low in the 2nd WAIT cycle → mem_req=0 immediately, no ack. After release, a new if_req completes normally with 3-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and data access,
//            with data priority and a fetch anti-starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy,
    output logic          busy,
    output logic          owner
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [SW-1:0] C_ONE        = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic          w_grant_data;
    logic [SW-1:0] w_starve_inc;

    // Data wins unless fetch has already waited through STARVE_MAX data grants.
    assign w_grant_data = d_req && !(if_req && (starve_cnt == C_STARVE_MAX));
    assign w_starve_inc = (starve_cnt == C_STARVE_MAX) ? C_STARVE_MAX
                                                      : starve_cnt + C_ONE;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            owner      <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        mem_req <= 1'b1;
                        state   <= S_WAIT;
                        if (w_grant_data) begin
                            owner      <= 1'b1;
                            mem_we     <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            starve_cnt <= if_req ? w_starve_inc : '0;
                        end else begin
                            owner      <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            starve_cnt <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rdy) begin
                        if (!mem_we) begin
                            if (owner) d_rdata  <= mem_rdata;
                            else       if_rdata <= mem_rdata;
                        end
                        // Ack is registered here so it is high for exactly the RESP cycle.
                        if (owner) d_ack  <= 1'b1;
                        else       if_ack <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;
    logic        busy;
    logic        owner;

    int errors;
    int checks;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        if_addr = 32'h0000_0500; d_addr = 32'h0000_1000; d_wdata = 32'h1234_5678;
        mem_rdy = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) step();
        checks++;
        if ({mem_req, mem_we, if_ack, d_ack, busy, owner} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000", {mem_req, mem_we, if_ack, d_ack, busy, owner});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, d_rdata});
        end
        mem_rdy = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if ({mem_req, owner, mem_we, busy} !== 4'b1111 || mem_addr !== 32'h0000_1000 || mem_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_first_grant: got req/own/we/busy=%b addr=%h wdata=%h required 1111 00001000 12345678",
                     {mem_req, owner, mem_we, busy}, mem_addr, mem_wdata);
        end
        // Asynchronous reset between edges.
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, busy, owner} !== 4'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: got ctrl=%b addr=%h required 0000 0", {mem_req, mem_we, busy, owner}, mem_addr);
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h0000_0100;
        step();
        checks++;
        if ({mem_req, mem_we, owner, busy, if_ack} !== 5'b10010 || mem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL fetch_cycle1: got req/we/own/busy/ack=%b addr=%h required 10010 00000100",
                     {mem_req, mem_we, owner, busy, if_ack}, mem_addr);
        end
        mem_rdy = 1'b1; mem_rdata = 32'hE3A0_0001;
        step();
        checks++;
        if ({if_ack, d_ack, mem_req} !== 3'b100 || if_rdata !== 32'hE3A0_0001) begin
            errors++;
            $display("FAIL fetch_cycle2: got ack/dack/req=%b rdata=%h required 100 e3a00001",
                     {if_ack, d_ack, mem_req}, if_rdata);
        end
        if_req = 1'b0; mem_rdy = 1'b0;
        step();
        checks++;
        if ({busy, if_ack} !== 2'b00 || if_rdata !== 32'hE3A0_0001) begin
            errors++;
            $display("FAIL fetch_cycle3: got busy/ack=%b rdata=%h required 00 e3a00001", {busy, if_ack}, if_rdata);
        end
    endtask

    task automatic test_collision();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        if_req = 1'b1; if_addr = 32'h0000_0104;
        step();
        checks++;
        if (owner !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL collision_data_first: got owner=%b addr=%h we=%b required 1 00002000 0", owner, mem_addr, mem_we);
        end
        mem_rdy = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        checks++;
        if ({d_ack, if_ack} !== 2'b10 || d_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL collision_data_ack: got dack/iack=%b rdata=%h required 10 11223344", {d_ack, if_ack}, d_rdata);
        end
        d_req = 1'b0; mem_rdy = 1'b0;
        step();
        step();
        checks++;
        if (owner !== 1'b0 || mem_addr !== 32'h0000_0104 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL collision_fetch_next: got owner=%b addr=%h req=%b required 0 00000104 1", owner, mem_addr, mem_req);
        end
        mem_rdy = 1'b1; mem_rdata = 32'h5566_7788;
        step();
        checks++;
        if ({if_ack, d_ack} !== 2'b10 || if_rdata !== 32'h5566_7788 || d_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL collision_fetch_ack: got acks=%b irdata=%h drdata=%h required 10 55667788 11223344",
                     {if_ack, d_ack}, if_rdata, d_rdata);
        end
        if_req = 1'b0; mem_rdy = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        logic [5:0] exp_owner;
        logic [1:0] exp_cnt [6];
        exp_owner = 6'b011011;  // bit i = owner of grant i: D,D,F,D,D,F
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd0;
        exp_cnt[3] = 2'd1; exp_cnt[4] = 2'd2; exp_cnt[5] = 2'd0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000;
        if_req = 1'b1; if_addr = 32'h0000_0200;
        mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (mem_req !== 1'b1 && n < 5);
            checks++;
            if (mem_req !== 1'b1) begin
                errors++;
                $display("FAIL starve_grant_timeout[%0d]: got mem_req=%b required 1 within 5 cycles", i, mem_req);
            end
            checks++;
            if (owner !== exp_owner[i] || dut.starve_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL starve_order[%0d]: got owner=%b cnt=%0d required %b %0d",
                         i, owner, dut.starve_cnt, exp_owner[i], exp_cnt[i]);
            end
            mem_rdata = 32'hA000_0000 + 32'(i);
            step();
            checks++;
            if (exp_owner[i]) begin
                if ({d_ack, if_ack} !== 2'b10 || d_rdata !== mem_rdata) begin
                    errors++;
                    $display("FAIL starve_dack[%0d]: got acks=%b rdata=%h required 10 %h", i, {d_ack, if_ack}, d_rdata, mem_rdata);
                end
                exp_d_rdata = mem_rdata;
            end else begin
                if ({if_ack, d_ack} !== 2'b10 || if_rdata !== mem_rdata) begin
                    errors++;
                    $display("FAIL starve_iack[%0d]: got acks=%b rdata=%h required 10 %h", i, {if_ack, d_ack}, if_rdata, mem_rdata);
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0; mem_rdy = 1'b0;
        step();
    endtask

    task automatic test_delayed_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'hDEAD_BEEF;
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({mem_req, mem_we, owner, d_ack} !== 4'b1110 || mem_addr !== 32'h0000_3000 || mem_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL write_wait[%0d]: got req/we/own/ack=%b addr=%h wdata=%h required 1110 00003000 deadbeef",
                         k, {mem_req, mem_we, owner, d_ack}, mem_addr, mem_wdata);
            end
            // Non-owner activity and an early d_req drop must not disturb the transaction.
            if (k == 0) begin if_req = 1'b1; if_addr = 32'h0000_0999; d_wdata = 32'h0; d_addr = 32'h0; end
            if (k == 1) d_req = 1'b0;
            if (k == 2) if_req = 1'b0;
            if (k == 3) begin mem_rdy = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
            step();
        end
        checks++;
        if ({d_ack, if_ack, mem_req, mem_we} !== 4'b1000 || d_rdata !== exp_d_rdata) begin
            errors++;
            $display("FAIL write_ack: got ack/iack/req/we=%b rdata=%h required 1000 %h",
                     {d_ack, if_ack, mem_req, mem_we}, d_rdata, exp_d_rdata);
        end
        mem_rdy = 1'b0; d_we = 1'b0;
        step();
        checks++;
        if ({busy, d_ack} !== 2'b00) begin
            errors++;
            $display("FAIL write_idle: got busy/ack=%b required 00", {busy, d_ack});
        end
    endtask

    task automatic test_reset_mid_wait();
        if_req = 1'b1; if_addr = 32'h0000_0300;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, if_ack, d_ack} !== 4'b0000 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midwait_reset: got req/busy/acks=%b addr=%h required 0000 0", {mem_req, busy, if_ack, d_ack}, mem_addr);
        end
        if_req = 1'b0; mem_rdy = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        reset = 1'b1;
        step();
        step();
        checks++;
        if ({busy, if_ack, d_ack, mem_req} !== 4'b0000 || if_rdata !== 32'h0) begin
            errors++;
            $display("FAIL late_rdy_ignored: got busy/acks/req=%b rdata=%h required 0000 0", {busy, if_ack, d_ack, mem_req}, if_rdata);
        end
        mem_rdy = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0400;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0400 || owner !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: got req=%b addr=%h owner=%b required 1 00000400 0", mem_req, mem_addr, owner);
        end
        mem_rdy = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        checks++;
        if (if_ack !== 1'b1 || if_rdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL post_reset_ack: got ack=%b rdata=%h required 1 cafef00d", if_ack, if_rdata);
        end
        if_req = 1'b0; mem_rdy = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b required 0", busy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_d_rdata = 32'h0;
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_rdy = 1'b0;
        #1;
        test_reset();
        test_single_fetch();
        test_collision();
        exp_d_rdata = 32'h1122_3344;
        test_starvation();
        test_delayed_write();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
